// File: rtl/calc_cursor_ctrl.sv
// calc_cursor_ctrl: debounces 5 raw buttons (up/down/left/right/ok), moves cursor_x/cursor_y on the keypad grid with auto-repeat, and emits the highlighted key's ASCII code over key_valid/key_ready with a key_drop pulse
module calc_cursor_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd500000,
  parameter logic [25:0] REPEAT_DLY = 26'd25000000,
  parameter logic [25:0] REPEAT_PER = 26'd5000000,
  parameter int GRID_COLS = 3,
  parameter int GRID_ROWS = 4
) (
  input  logic       clk_in,
  input  logic       sys_rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_ok,
  output logic [3:0] cursor_x,
  output logic [3:0] cursor_y,
  output logic       key_valid,
  output logic [7:0] key_code,
  input  logic       key_ready,
  output logic       key_drop
);
  typedef enum logic {IDLE, HOLD} state_t;
  localparam logic [3:0] COLS4 = 4'(GRID_COLS);
  localparam logic [3:0] ROWS4 = 4'(GRID_ROWS);
  localparam logic [95:0] KEY_STR = "123456789+0=";
  logic [4:0] raw, press;
  logic [3:0] rpt;
  assign raw = {btn_ok, btn_right, btn_left, btn_down, btn_up};
  for (genvar g = 0; g < 5; g++) begin : g_btn
    logic [1:0] sync_q;
    logic [19:0] cnt_q, cnt_d;
    logic st_q, st_d, dly_q, press_q, press_d;
    always_comb begin
      cnt_d = (sync_q[1] == st_q || cnt_q == DEBOUNCE_CYC - 20'd1) ? '0 : cnt_q + 20'd1;
      st_d = (sync_q[1] != st_q && cnt_q == DEBOUNCE_CYC - 20'd1) ? sync_q[1] : st_q;
      press_d = st_q & ~dly_q;
    end
    always_ff @(posedge clk_in) begin
      if (sys_rst) begin
        sync_q <= '0;
        cnt_q <= '0;
        st_q <= 1'b0;
        dly_q <= 1'b0;
        press_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[0], raw[g]};
        cnt_q <= cnt_d;
        st_q <= st_d;
        dly_q <= st_q;
        press_q <= press_d;
      end
    end
    assign press[g] = press_q;
    if (g < 4) begin : g_rpt
      logic [25:0] hc_q, hc_d;
      logic first_q, first_d, rpt_w;
      always_comb begin
        rpt_w = st_q && REPEAT_DLY != '0 && hc_q == (first_q ? REPEAT_DLY : REPEAT_PER);
        hc_d = (press_q || rpt_w) ? 26'd1 : st_q ? hc_q + 26'd1 : '0;
        first_d = press_q ? 1'b1 : rpt_w ? 1'b0 : st_q ? first_q : 1'b1;
      end
      always_ff @(posedge clk_in) begin
        if (sys_rst) begin
          hc_q <= '0;
          first_q <= 1'b1;
        end else begin
          hc_q <= hc_d;
          first_q <= first_d;
        end
      end
      assign rpt[g] = rpt_w;
    end
  end
  logic mu, md, ml, mr, ok, load;
  logic [3:0] cursor_x_q, cursor_x_d, cursor_y_q, cursor_y_d;
  logic [7:0] key_code_q, key_code_d, idx, kc;
  logic [95:0] shifted;
  logic key_drop_q, key_drop_d;
  state_t state_q, state_d;
  always_comb begin
    {mr, ml, md, mu} = press[3:0] | rpt;
    ok = press[4];
    cursor_y_d = mu ? ((cursor_y_q == 4'd0 || cursor_y_q >= ROWS4) ? ROWS4 - 4'd1 : cursor_y_q - 4'd1)
               : md ? ((cursor_y_q >= ROWS4 - 4'd1) ? 4'd0 : cursor_y_q + 4'd1)
               : cursor_y_q;
    cursor_x_d = (mu | md) ? cursor_x_q
               : ml ? ((cursor_x_q == 4'd0 || cursor_x_q >= COLS4) ? COLS4 - 4'd1 : cursor_x_q - 4'd1)
               : mr ? ((cursor_x_q >= COLS4 - 4'd1) ? 4'd0 : cursor_x_q + 4'd1)
               : cursor_x_q;
    idx = 8'(cursor_y_q) * 8'(GRID_COLS) + 8'(cursor_x_q);
    shifted = KEY_STR << {idx, 3'b000};
    kc = idx < 8'd12 ? shifted[95:88] : 8'h00;
    load = ok && (state_q == IDLE || key_ready);
    state_d = (ok || (state_q == HOLD && !key_ready)) ? HOLD : IDLE;
    key_code_d = load ? kc : key_code_q;
    key_drop_d = ok && state_q == HOLD && !key_ready;
  end
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      cursor_x_q <= '0;
      cursor_y_q <= '0;
      key_code_q <= '0;
      key_drop_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      key_code_q <= key_code_d;
      key_drop_q <= key_drop_d;
      state_q <= state_d;
    end
  end
  assign cursor_x = cursor_x_q;
  assign cursor_y = cursor_y_q;
  assign key_valid = state_q == HOLD;
  assign key_code = key_code_q;
  assign key_drop = key_drop_q;
endmodule

// File: tb/tb_calc_cursor_ctrl.sv
// tb_calc_cursor_ctrl: directed self-checking bench for calc_cursor_ctrl with a key_code scoreboard
module tb_calc_cursor_ctrl;
  logic clk_in = 1'b0;
  logic sys_rst, key_ready, key_valid, key_drop;
  logic [4:0] btn;
  logic [3:0] cursor_x, cursor_y;
  logic [7:0] key_code;
  int errors = 0;
  int checks = 0;
  logic [7:0] sb [$];
  calc_cursor_ctrl #(
    .DEBOUNCE_CYC(20'd4),
    .REPEAT_DLY(26'd20),
    .REPEAT_PER(26'd8)
  ) dut (
    .clk_in(clk_in),
    .sys_rst(sys_rst),
    .btn_up(btn[0]),
    .btn_down(btn[1]),
    .btn_left(btn[2]),
    .btn_right(btn[3]),
    .btn_ok(btn[4]),
    .cursor_x(cursor_x),
    .cursor_y(cursor_y),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_ready(key_ready),
    .key_drop(key_drop)
  );
  always #5 clk_in = ~clk_in;
  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pos(input string tag, input logic [3:0] x, input logic [3:0] y);
    chk({tag, "_x"}, {28'd0, cursor_x}, {28'd0, x});
    chk({tag, "_y"}, {28'd0, cursor_y}, {28'd0, y});
  endtask
  task automatic tap(input int b, output int drops);
    drops = 0;
    btn[b] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      drops += int'(key_drop);
    end
    btn[b] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      drops += int'(key_drop);
    end
  endtask
  task automatic handshake(input string tag);
    logic [7:0] exp;
    key_ready = 1'b1;
    chk({tag, "_valid_before"}, {31'd0, key_valid}, 32'd1);
    if (sb.size() == 0) chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    else begin
      exp = sb.pop_front();
      chk({tag, "_code"}, {24'd0, key_code}, {24'd0, exp});
    end
    step(1);
    key_ready = 1'b0;
    chk({tag, "_valid_after"}, {31'd0, key_valid}, 32'd0);
  endtask
  initial begin
    int d;
    btn = '0;
    key_ready = 1'b0;
    sys_rst = 1'b1;
    step(3);
    sys_rst = 1'b0;
    pos("reset", 4'd0, 4'd0);
    chk("reset_valid", {31'd0, key_valid}, 32'd0);
    chk("reset_code", {24'd0, key_code}, 32'd0);
    for (int i = 0; i < 100; i++) begin
      chk("idle_drop", {31'd0, key_drop}, 32'd0);
      chk("idle_valid", {31'd0, key_valid}, 32'd0);
      step(1);
    end
    btn[3] = 1'b1;
    step(3);
    btn[3] = 1'b0;
    step(12);
    pos("short_pulse", 4'd0, 4'd0);
    btn[3] = 1'b1;
    step(7);
    pos("right_t6", 4'd0, 4'd0);
    step(1);
    pos("right_t7", 4'd1, 4'd0);
    btn[3] = 1'b0;
    step(12);
    pos("right_release", 4'd1, 4'd0);
    tap(3, d); pos("to_2_0", 4'd2, 4'd0);
    tap(3, d); pos("wrap_right", 4'd0, 4'd0);
    tap(0, d); pos("wrap_up", 4'd0, 4'd3);
    tap(2, d); pos("wrap_left", 4'd2, 4'd3);
    tap(2, d); pos("to_1_3", 4'd1, 4'd3);
    sb.push_back(8'h30);
    tap(4, d);
    chk("ok_no_drop", d, 32'd0);
    chk("ok_valid", {31'd0, key_valid}, 32'd1);
    chk("ok_code", {24'd0, key_code}, 32'h30);
    step(10);
    chk("hold_valid", {31'd0, key_valid}, 32'd1);
    tap(3, d); pos("hold_move", 4'd2, 4'd3);
    tap(4, d);
    chk("drop_pulses", d, 32'd1);
    chk("drop_code", {24'd0, key_code}, 32'h30);
    handshake("hs0");
    chk("hs0_retained", {24'd0, key_code}, 32'h30);
    sb.push_back(8'h3D);
    tap(4, d);
    chk("eq_code", {24'd0, key_code}, 32'h3D);
    handshake("hs1");
    btn[1] = 1'b1;
    step(8);  pos("rep_press", 4'd2, 4'd0);
    step(19); pos("rep_pre20", 4'd2, 4'd0);
    step(1);  pos("rep_20", 4'd2, 4'd1);
    step(7);  pos("rep_pre28", 4'd2, 4'd1);
    step(1);  pos("rep_28", 4'd2, 4'd2);
    step(8);  pos("rep_36", 4'd2, 4'd3);
    step(8);  pos("rep_44", 4'd2, 4'd0);
    step(8);  pos("rep_52", 4'd2, 4'd1);
    step(4);
    sys_rst = 1'b1;
    btn[1] = 1'b0;
    step(2);
    sys_rst = 1'b0;
    pos("mid_hold_reset", 4'd0, 4'd0);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_code", {24'd0, key_code}, 32'd0);
    step(40);
    pos("no_move_after_rst", 4'd0, 4'd0);
    tap(1, d); pos("repress_down", 4'd0, 4'd1);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
